// File: rtl/hack_alu_pkg.sv
// Shared definitions for the Hack-style ALU: datapath width, the packed
// control word and the named function codes used by the CPU decoder.
package hack_alu_pkg;

   localparam int ALU_WIDTH = 16;

   // Control word, most significant field first: {zx,nx,zy,ny,f,no}
   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;

   // Named function codes
   localparam alu_ctrl_t ZERO    = 6'b101010;
   localparam alu_ctrl_t ONE     = 6'b111111;
   localparam alu_ctrl_t NEG_ONE = 6'b111010;
   localparam alu_ctrl_t X       = 6'b001100;
   localparam alu_ctrl_t Y       = 6'b110000;
   localparam alu_ctrl_t NOT_X   = 6'b001101;
   localparam alu_ctrl_t NOT_Y   = 6'b110001;
   localparam alu_ctrl_t NEG_X   = 6'b001111;
   localparam alu_ctrl_t NEG_Y   = 6'b110011;
   localparam alu_ctrl_t X_INC   = 6'b011111;
   localparam alu_ctrl_t Y_INC   = 6'b110111;
   localparam alu_ctrl_t X_DEC   = 6'b001110;
   localparam alu_ctrl_t Y_DEC   = 6'b110010;
   localparam alu_ctrl_t X_ADD_Y = 6'b000010;
   localparam alu_ctrl_t X_SUB_Y = 6'b010011;
   localparam alu_ctrl_t Y_SUB_X = 6'b000111;
   localparam alu_ctrl_t X_AND_Y = 6'b000000;
   localparam alu_ctrl_t X_OR_Y  = 6'b010101;

   // Gather the six loose control bits into one control word
   function automatic alu_ctrl_t ctrl_pack(input logic zx, input logic nx,
                                           input logic zy, input logic ny,
                                           input logic f,  input logic no);
      alu_ctrl_t c;
      c.zx = zx;
      c.nx = nx;
      c.zy = zy;
      c.ny = ny;
      c.f  = f;
      c.no = no;
      return c;
   endfunction

endpackage

// File: rtl/hack_alu_if.sv
// Request/result bundle between the ALU and its datapath neighbours.
// The master issues operands and controls; the slave (the ALU) returns
// the registered result and flags.
interface hack_alu_if
   import hack_alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             zx;
   logic             nx;
   logic             zy;
   logic             ny;
   logic             f;
   logic             no;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic             zr;
   logic             ng;

   modport master (
      output in_valid, x, y, zx, nx, zy, ny, f, no,
      input  out_valid, out, zr, ng
   );

   modport slave (
      input  in_valid, x, y, zx, nx, zy, ny, f, no,
      output out_valid, out, zr, ng
   );
endinterface

// File: rtl/hack_alu_core.sv
// Purely combinational Hack ALU core: operand conditioning (zero, then
// invert), add or AND, optional output inversion, then zero/negative flags.
module hack_alu_core
   import hack_alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  alu_ctrl_t        ctrl,
   output logic [WIDTH-1:0] res,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] x1_s;
   logic [WIDTH-1:0] x2_s;
   logic [WIDTH-1:0] y1_s;
   logic [WIDTH-1:0] y2_s;
   logic [WIDTH-1:0] r_s;

   // Condition operands in strict order: zero first, then invert
   always_comb begin
      x1_s = {WIDTH{1'b0}};
      x2_s = {WIDTH{1'b0}};
      y1_s = {WIDTH{1'b0}};
      y2_s = {WIDTH{1'b0}};
      if (ctrl.zx) begin
         x1_s = {WIDTH{1'b0}};
      end else begin
         x1_s = x;
      end
      if (ctrl.nx) begin
         x2_s = ~x1_s;
      end else begin
         x2_s = x1_s;
      end
      if (ctrl.zy) begin
         y1_s = {WIDTH{1'b0}};
      end else begin
         y1_s = y;
      end
      if (ctrl.ny) begin
         y2_s = ~y1_s;
      end else begin
         y2_s = y1_s;
      end
   end

   // Select add (carry dropped) or AND, then optionally invert the result
   always_comb begin
      r_s = {WIDTH{1'b0}};
      res = {WIDTH{1'b0}};
      if (ctrl.f) begin
         r_s = x2_s + y2_s;
      end else begin
         r_s = x2_s & y2_s;
      end
      if (ctrl.no) begin
         res = ~r_s;
      end else begin
         res = r_s;
      end
   end

   // Derive flags from the final result
   always_comb begin
      zr = 1'b0;
      ng = 1'b0;
      if (res == {WIDTH{1'b0}}) begin
         zr = 1'b1;
      end else begin
         zr = 1'b0;
      end
      ng = res[WIDTH-1];
   end

endmodule

// File: rtl/hack_alu.sv
// Registered Hack-style ALU. The combinational core is followed by one
// register stage; a result and its flags load on every valid request and
// hold otherwise, while out_valid marks the cycle a fresh result appears.
module hack_alu
   import hack_alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic   clk,
   input  logic   rst_n,
   hack_alu_if.slave bus
);

   alu_ctrl_t        ctrl_s;
   logic [WIDTH-1:0] res_s;
   logic             zr_s;
   logic             ng_s;

   logic [WIDTH-1:0] out_r;
   logic             zr_r;
   logic             ng_r;
   logic             valid_r;

   assign ctrl_s = ctrl_pack(bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no);

   hack_alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .x    (bus.x),
      .y    (bus.y),
      .ctrl (ctrl_s),
      .res  (res_s),
      .zr   (zr_s),
      .ng   (ng_s)
   );

   // Result register: load on valid, otherwise hold; reset leaves a
   // self-consistent zero result (zr set) with nothing valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r   <= {WIDTH{1'b0}};
         zr_r    <= 1'b1;
         ng_r    <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            out_r <= res_s;
            zr_r  <= zr_s;
            ng_r  <= ng_s;
         end else begin
            out_r <= out_r;
            zr_r  <= zr_r;
            ng_r  <= ng_r;
         end
      end
   end

   assign bus.out       = out_r;
   assign bus.zr        = zr_r;
   assign bus.ng        = ng_r;
   assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_hack_alu.sv
// Directed testbench for hack_alu: every expected value is hand-computed.
module tb_hack_alu;
   import hack_alu_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   hack_alu_if #(.WIDTH(16)) bus ();

   hack_alu #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Put one request on the bus at the falling edge; return 1 time unit
   // after the capturing rising edge with in_valid dropped again
   task automatic drive(input alu_ctrl_t op, input logic [15:0] xv, input logic [15:0] yv);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x        = xv;
      bus.y        = yv;
      {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = op;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Run a table of operations on fixed operands and compare each result
   task automatic run_table(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                            input alu_ctrl_t ops[], input logic [15:0] exps[]);
      logic [15:0] e;
      for (int i = 0; i < ops.size(); i++) begin
         drive(ops[i], xv, yv);
         e = exps[i];
         checks++;
         if (bus.out !== e || bus.zr !== (e == 16'h0000) || bus.ng !== e[15] ||
             bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d]: got out=%h zr=%b ng=%b vld=%b, expected out=%h zr=%b ng=%b vld=1",
                     tag, i, bus.out, bus.zr, bus.ng, bus.out_valid, e, (e == 16'h0000), e[15]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.x        = 16'h0000;
      bus.y        = 16'h0000;
      {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b000000;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.out !== 16'h0000 || bus.zr !== 1'b1 || bus.ng !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: got out=%h zr=%b ng=%b vld=%b, expected 0000 1 0 0",
                  bus.out, bus.zr, bus.ng, bus.out_valid);
      end
      rst_n = 1'b1;
      drive(NEG_ONE, 16'h0000, 16'h0000);
      checks++;
      if (bus.out !== 16'hFFFF || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_op: got out=%h vld=%b, expected FFFF 1", bus.out, bus.out_valid);
      end
      // Assert reset mid-cycle with a request still pending
      bus.in_valid = 1'b1;
      {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ONE;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out !== 16'h0000 || bus.zr !== 1'b1 || bus.ng !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got out=%h zr=%b ng=%b vld=%b, expected 0000 1 0 0",
                  bus.out, bus.zr, bus.ng, bus.out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: got out=%h vld=%b, expected 0000 0", bus.out, bus.out_valid);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
   endtask

   task automatic test_constants();
      run_table("const", 16'h1248, 16'h137F, '{ZERO, ONE, NEG_ONE}, '{16'h0000, 16'h0001, 16'hFFFF});
   endtask

   task automatic test_pass_invert();
      run_table("pass", 16'h1248, 16'h137F, '{X, Y, NOT_X, NOT_Y},
                '{16'h1248, 16'h137F, 16'hEDB7, 16'hEC80});
   endtask

   task automatic test_neg_inc_dec();
      run_table("arith", 16'hFACA, 16'h7AFA, '{NEG_X, NEG_Y, X_INC, Y_INC, X_DEC, Y_DEC},
                '{16'h0536, 16'h8506, 16'hFACB, 16'h7AFB, 16'hFAC9, 16'h7AF9});
   endtask

   task automatic test_add_sub();
      run_table("addsub", 16'd42, 16'd129, '{X_ADD_Y, X_SUB_Y, Y_SUB_X},
                '{16'h00AB, 16'hFFA9, 16'h0057});
   endtask

   task automatic test_logic();
      run_table("logic", 16'h3333, 16'h5555, '{X_AND_Y, X_OR_Y}, '{16'h1111, 16'h7777});
      run_table("and_zero", 16'hFFFF, 16'h0000, '{X_AND_Y}, '{16'h0000});
   endtask

   task automatic test_hold();
      drive(X_ADD_Y, 16'h0100, 16'h0023);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.x = 16'h1111 * i[15:0];
         bus.y = 16'h8000;
         @(posedge clk);
         #1;
         checks++;
         if (bus.out !== 16'h0123 || bus.zr !== 1'b0 || bus.ng !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got out=%h zr=%b ng=%b vld=%b, expected 0123 0 0 0",
                     i, bus.out, bus.zr, bus.ng, bus.out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      alu_ctrl_t   ops[4];
      logic [15:0] exps[4];
      logic [15:0] e;
      ops  = '{X, Y_INC, X_SUB_Y, ZERO};
      exps = '{16'h0005, 16'h0004, 16'h0002, 16'h0000};
      @(negedge clk);
      bus.x = 16'h0005;
      bus.y = 16'h0003;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ops[i];
         @(posedge clk);
         #1;
         e = exps[i];
         checks++;
         if (bus.out !== e || bus.zr !== (e == 16'h0000) || bus.ng !== e[15] ||
             bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b[%0d]: got out=%h zr=%b ng=%b vld=%b, expected out=%h vld=1",
                     i, bus.out, bus.zr, bus.ng, bus.out_valid, e);
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || bus.zr !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drop: got out=%h zr=%b vld=%b, expected 0000 1 0",
                  bus.out, bus.zr, bus.out_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_constants();
      test_pass_invert();
      test_neg_inc_dec();
      test_add_sub();
      test_logic();
      test_hold();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hack_alu.md
Name: hack_alu

Overview:
- Registered 16-bit Hack-style ALU: six control bits select a function of x and y (0, ±1, x, y, !x, !y, -x, -y, x±1, y±1, x+y, x-y, y-x, x&y, x|y).
- Produces result plus zero and negative flags, registered one cycle after a valid request.
- Sits in the CPU datapath between the register file/A-D registers and writeback.

Parameters:
WIDTH, 16, datapath width in bits (x, y, out); ng reports bit WIDTH-1.

Ports:
clk  input  1  single clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and controls valid this cycle; capture on clk rise
x  input  WIDTH  operand x
y  input  WIDTH  operand y
zx  input  1  zero x before nx
nx  input  1  bitwise invert x after zx
zy  input  1  zero y before ny
ny  input  1  bitwise invert y after zy
f  input  1  1 = add, 0 = bitwise AND
no  input  1  bitwise invert function result
out_valid  output  1  out/zr/ng hold a newly computed result
out  output  WIDTH  registered result
zr  output  1  registered: 1 when out == 0
ng  output  1  registered: out[WIDTH-1]

Behaviour:
- Clocking and reset: one clock domain (clk); asynchronous active-low reset rst_n.
- Combinational core, applied in strict order:
  - x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1.
  - y1 = zy ? 0 : y; y2 = ny ? ~y1 : y1.
  - r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2). Carry out is discarded; no overflow flag.
  - res = no ? ~r : r.
- Flags are computed from res: zr = (res == 0); ng = res[WIDTH-1].
- Latency is exactly 1 cycle. On the clk rising edge with in_valid=1, out/zr/ng load res and its flags, and out_valid goes to 1.
- On a clk rising edge with in_valid=0, out/zr/ng hold their previous values and out_valid goes to 0.
- Back-to-back valid requests give one result per cycle. There is no backpressure and no ready signal.
- Reset (rst_n=0, asynchronous assert, removal synchronous to clk):
  - out = 0, zr = 1 (consistent with out = 0), ng = 0, out_valid = 0.
  - Reset mid-operation discards any pending result. The first capture after release occurs on the first clk rise with rst_n=1 and in_valid=1.
- All 64 control combinations are legal and follow the equations above; there are no illegal codes and no X propagation from unused combinations.

Decomposition:
- Shared package hack_alu_pkg:
  - ALU_WIDTH = 16.
  - Named 6-bit control constants in order {zx,nx,zy,ny,f,no}: ZERO=101010, ONE=111111, NEG_ONE=111010, X=001100, Y=110000, NOT_X=001101, NOT_Y=110001, NEG_X=001111, NEG_Y=110011, X_INC=011111, Y_INC=110111, X_DEC=001110, Y_DEC=110010, X_ADD_Y=000010, X_SUB_Y=010011, Y_SUB_X=000111, X_AND_Y=000000, X_OR_Y=010101.
- One natural sub-module: hack_alu_core. It is purely combinational (x, y, six controls -> res, zr, ng). The top adds the valid/output register stage.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out=0000, zr=1, ng=0, out_valid=0 immediately, without waiting for a clk edge.
- Constants, x=1248 y=137F:
  - ZERO -> out=0000, zr=1, ng=0.
  - ONE -> 0001, zr=0, ng=0.
  - NEG_ONE -> FFFF, ng=1.
- Pass and invert, x=1248 y=137F:
  - X -> 1248; Y -> 137F.
  - NOT_X -> EDB7, ng=1; NOT_Y -> EC80, ng=1.
- Negate, increment, decrement, x=FACA y=7AFA:
  - NEG_X -> 0536; NEG_Y -> 8506, ng=1.
  - X_INC -> FACB; Y_INC -> 7AFB.
  - X_DEC -> FAC9; Y_DEC -> 7AF9.
- Add and subtract, x=42 y=129 (decimal): X_ADD_Y -> 00AB; X_SUB_Y -> FFA9, ng=1; Y_SUB_X -> 0057, ng=0.
- Logic, handshake and latency:
  - x=3333 y=5555: X_AND_Y -> 1111; X_OR_Y -> 7777.
  - x=FFFF y=0000, X_AND_Y -> 0000, zr=1.
  - Every result appears exactly one clk after in_valid=1 with out_valid=1.
  - in_valid=0 with changing x/y -> out holds and out_valid=0.
  - Back-to-back valids -> one result per cycle.
